hub75_fb_multibuf: RTL and testbench



---
 rtl/hub75_fb_multibuf.sv | 198 +++++++++++++++++++
 tb/tb_hub75_fb_multibuf.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_fb_multibuf.sv
// HUB75 framebuffer with round-robin access arbiter and double/triple buffering.
// Client 0 draws into draw_buf; clients 1..N_CLIENTS-1 read from disp_buf.
module hub75_fb_multibuf #(
  parameter int N_BANKS   = 2,
  parameter int N_ROWS    = 32,
  parameter int N_COLS    = 64,
  parameter int FB_DW     = 16,
  parameter int FB_DC     = 2,
  parameter int N_BUFS    = 3,
  parameter int N_CLIENTS = 3,
  parameter int CA_W      = $clog2(N_BANKS) + $clog2(N_ROWS) + $clog2(N_COLS) + $clog2(FB_DC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CLIENTS-1:0]      c_req,
  output logic [N_CLIENTS-1:0]      c_gnt,
  input  logic [N_CLIENTS-1:0]      c_rel,
  input  logic [N_CLIENTS*CA_W-1:0] c_addr,
  input  logic [N_CLIENTS-1:0]      c_rd,
  input  logic [FB_DW-1:0]          wr_data,
  input  logic                      wr_en,
  output logic [FB_DW-1:0]          rd_data,
  output logic [N_CLIENTS-1:0]      rd_valid,
  input  logic                      frame_done,
  input  logic                      frame_sync,
  output logic                      wr_ok,
  output logic [1:0]                draw_buf,
  output logic [1:0]                disp_buf,
  output logic                      swap_pending,
  output logic [7:0]                drop_cnt
);

  localparam int CW    = $clog2(N_CLIENTS);
  localparam int BW    = (N_BUFS == 2) ? 1 : 2;
  localparam int MA_W  = BW + CA_W;
  localparam int DEPTH = 1 << MA_W;
  localparam logic [CW-1:0] LAST_INIT = CW'(N_CLIENTS - 1);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0 = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} arb_st_e;

  arb_st_e              state_r, state_nx_s;
  logic [CW-1:0]        last_r, owner_r;
  logic [CW-1:0]        pick_s, idx_s;
  logic                 any_req_s, hit_s, rel_s, grant_s;
  logic [N_CLIENTS-1:0] gnt_nx_s;
  logic                 we_s, rd_s;
  logic [CA_W-1:0]      cur_addr_s;
  logic [MA_W-1:0]      mem_addr_s;

  logic [N_CLIENTS-1:0] c_gnt_r, rd_valid_r;
  logic [FB_DW-1:0]     rd_data_r;
  logic [FB_DW-1:0]     mem_r [DEPTH];

  logic [1:0] disp_r, draw_r, spare_r, disp_nx_s, draw_nx_s, spare_nx_s;
  logic       pend_r, pend_nx_s, wr_ok_r, wr_ok_nx_s;
  logic [7:0] drop_r, drop_nx_s;

  // Arbiter state register: owner and last-grant are captured at the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      last_r  <= LAST_INIT;
      owner_r <= '0;
    end else begin
      state_r <= state_nx_s;
      if (grant_s) begin
        last_r  <= pick_s;
        owner_r <= pick_s;
      end
    end
  end

  // Arbiter next state: cyclic search starting just after the last granted client.
  always_comb begin
    pick_s    = last_r;
    any_req_s = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    // Descending scan so the nearest requester after last_r is the final winner.
    for (int k = N_CLIENTS; k >= 1; k--) begin
      idx_s     = CW'((int'(last_r) + k) % N_CLIENTS);
      hit_s     = c_req[idx_s];
      pick_s    = hit_s ? idx_s : pick_s;
      any_req_s = any_req_s | hit_s;
    end
    rel_s = c_rel[owner_r];
    case (state_r)
      ST_IDLE: state_nx_s = any_req_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_nx_s = rel_s ? ST_IDLE : ST_BUSY;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Arbiter outputs: grant pulse and owner-gated memory strobes.
  always_comb begin
    grant_s    = (state_r == ST_IDLE) && any_req_s;
    gnt_nx_s   = grant_s ? (ONE_HOT0 << pick_s) : '0;
    cur_addr_s = c_addr[owner_r*CA_W +: CA_W];
    we_s       = (state_r == ST_BUSY) && (owner_r == '0) && wr_en && wr_ok_r;
    rd_s       = (state_r == ST_BUSY) && (owner_r != '0) && c_rd[owner_r];
    mem_addr_s = {(rd_s ? disp_r[BW-1:0] : draw_r[BW-1:0]), cur_addr_s};
  end

  // Registered client-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_gnt_r    <= '0;
      rd_valid_r <= '0;
      rd_data_r  <= '0;
    end else begin
      c_gnt_r    <= gnt_nx_s;
      rd_valid_r <= rd_s ? (ONE_HOT0 << owner_r) : '0;
      if (rd_s) begin
        rd_data_r <= mem_r[mem_addr_s];
      end
    end
  end

  // Framebuffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[mem_addr_s] <= wr_data;
    end
  end

  // Buffer rotation: frame_done is applied before frame_sync in the same cycle.
  always_comb begin
    disp_nx_s  = disp_r;
    draw_nx_s  = draw_r;
    spare_nx_s = spare_r;
    pend_nx_s  = pend_r;
    wr_ok_nx_s = wr_ok_r;
    drop_nx_s  = drop_r;
    if (N_BUFS == 2) begin
      if (frame_done && !pend_r) begin
        pend_nx_s  = 1'b1;
        wr_ok_nx_s = 1'b0;
      end else begin
        pend_nx_s  = pend_r;
      end
      if (frame_sync && pend_nx_s) begin
        disp_nx_s  = draw_r;
        draw_nx_s  = disp_r;
        pend_nx_s  = 1'b0;
        wr_ok_nx_s = 1'b1;
      end else begin
        wr_ok_nx_s = wr_ok_nx_s;
      end
    end else begin
      wr_ok_nx_s = 1'b1;
      if (frame_done) begin
        draw_nx_s  = spare_r;
        spare_nx_s = draw_r;
        pend_nx_s  = 1'b1;
        drop_nx_s  = (pend_r && (drop_r != 8'hFF)) ? (drop_r + 8'd1) : drop_r;
      end else begin
        pend_nx_s  = pend_r;
      end
      if (frame_sync && pend_nx_s) begin
        disp_nx_s  = spare_nx_s;
        spare_nx_s = disp_r;
        pend_nx_s  = 1'b0;
      end else begin
        disp_nx_s  = disp_r;
      end
    end
  end

  // Buffer index and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_r  <= 2'd0;
      draw_r  <= 2'd1;
      spare_r <= 2'd2;
      pend_r  <= 1'b0;
      wr_ok_r <= 1'b1;
      drop_r  <= 8'd0;
    end else begin
      disp_r  <= disp_nx_s;
      draw_r  <= draw_nx_s;
      spare_r <= spare_nx_s;
      pend_r  <= pend_nx_s;
      wr_ok_r <= wr_ok_nx_s;
      drop_r  <= drop_nx_s;
    end
  end

  assign c_gnt        = c_gnt_r;
  assign rd_valid     = rd_valid_r;
  assign rd_data      = rd_data_r;
  assign wr_ok        = wr_ok_r;
  assign draw_buf     = draw_r;
  assign disp_buf     = disp_r;
  assign swap_pending = pend_r;
  assign drop_cnt     = drop_r;

endmodule

// File: tb/tb_hub75_fb_multibuf.sv
// Directed bench for hub75_fb_multibuf: triple-buffer instance (a_) and
// double-buffer instance (b_) driven from the same stimulus.
module tb_hub75_fb_multibuf;
  localparam int NC   = 3;
  localparam int CA_W = 1 + 5 + 6 + 1;
  localparam int DW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NC-1:0]     c_req, c_rel, c_rd;
  logic [NC*CA_W-1:0] c_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_en, frame_done, frame_sync;

  logic [NC-1:0] a_gnt, a_rd_valid, b_gnt, b_rd_valid;
  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          a_wr_ok, a_pend, b_wr_ok, b_pend;
  logic [1:0]    a_draw, a_disp, b_draw, b_disp;
  logic [7:0]    a_drop, b_drop;

  hub75_fb_multibuf #(.N_BUFS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .c_req(c_req), .c_gnt(a_gnt), .c_rel(c_rel),
    .c_addr(c_addr), .c_rd(c_rd), .wr_data(wr_data), .wr_en(wr_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .frame_done(frame_done),
    .frame_sync(frame_sync), .wr_ok(a_wr_ok), .draw_buf(a_draw), .disp_buf(a_disp),
    .swap_pending(a_pend), .drop_cnt(a_drop)
  );

  hub75_fb_multibuf #(.N_BUFS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .c_req(c_req), .c_gnt(b_gnt), .c_rel(c_rel),
    .c_addr(c_addr), .c_rd(c_rd), .wr_data(wr_data), .wr_en(wr_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .frame_done(frame_done),
    .frame_sync(frame_sync), .wr_ok(b_wr_ok), .draw_buf(b_draw), .disp_buf(b_disp),
    .swap_pending(b_pend), .drop_cnt(b_drop)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [NC-1:0] exp_gnt [3] = '{3'b001, 3'b010, 3'b100};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; c_req = '0; c_rel = '0; c_rd = '0; c_addr = '0;
    wr_data = '0; wr_en = 1'b0; frame_done = 1'b0; frame_sync = 1'b0;

    // reset values
    do_reset();
    check("rst_gnt", a_gnt, 3'b000);
    check("rst_rd_valid", a_rd_valid, 3'b000);
    check("rst_rd_data", a_rd_data, 16'h0000);
    check("rst_disp", a_disp, 2'd0);
    check("rst_draw", a_draw, 2'd1);
    check("rst_pend", a_pend, 1'b0);
    check("rst_wr_ok", a_wr_ok, 1'b1);
    check("rst_drop", a_drop, 8'd0);
    rst_n = 1'b1;

    // round robin with all requesting; stray releases must be ignored
    c_req = 3'b111;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rr_gnt", a_gnt, exp_gnt[i]);
      c_rel = ~exp_gnt[i];
      tick();
      c_rel = '0;
      check("rr_gnt_pulse", a_gnt, 3'b000);
      tick();
      check("rr_stray_rel", a_gnt, 3'b000);
      c_rel = exp_gnt[i];
      tick();
      c_rel = '0;
      check("rr_idle", a_gnt, 3'b000);
      tick();
    end
    check("rr_wrap_gnt", a_gnt, 3'b001);

    // writer owns the bus: write 0xA5A5 at addr 5, reader strobe ignored
    c_addr[0 +: CA_W] = CA_W'(5);
    c_addr[CA_W +: CA_W] = CA_W'(5);
    wr_data = 16'hA5A5;
    wr_en = 1'b1;
    c_rd = 3'b010;
    tick();
    wr_en = 1'b0;
    c_rd = '0;
    check("nonowner_rd", a_rd_valid, 3'b000);
    c_rel = 3'b001;
    c_req = '0;
    tick();
    c_rel = '0;

    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("done_pend", a_pend, 1'b1);
    check("done_draw", a_draw, 2'd2);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("sync_disp", a_disp, 2'd1);
    check("sync_pend", a_pend, 1'b0);

    // reader 1 fetches the displayed frame
    c_req = 3'b010;
    tick();
    check("rd_gnt", a_gnt, 3'b010);
    c_rd = 3'b010;
    tick();
    c_rd = '0;
    check("rd_data", a_rd_data, 16'hA5A5);
    check("rd_valid", a_rd_valid, 3'b010);
    tick();
    check("rd_valid_drop", a_rd_valid, 3'b000);
    c_rel = 3'b010;
    c_req = '0;
    tick();
    c_rel = '0;

    // three frame_done without frame_sync (disp1 draw2 spare0 at start)
    for (int i = 0; i < 3; i++) begin
      frame_done = 1'b1;
      tick();
    end
    frame_done = 1'b0;
    check("tri_drop", a_drop, 8'd2);
    check("tri_pend", a_pend, 1'b1);
    check("tri_wr_ok", a_wr_ok, 1'b1);
    check("tri_draw", a_draw, 2'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("tri_sync_disp", a_disp, 2'd2);

    // done and sync in the same cycle straight after reset
    do_reset();
    rst_n = 1'b1;
    frame_done = 1'b1;
    frame_sync = 1'b1;
    tick();
    frame_done = 1'b0;
    frame_sync = 1'b0;
    check("both_disp", a_disp, 2'd1);
    check("both_draw", a_draw, 2'd2);
    check("both_pend", a_pend, 1'b0);

    // drop counter saturation: 1 set + 257 drops
    frame_done = 1'b1;
    for (int i = 0; i < 258; i++) tick();
    frame_done = 1'b0;
    check("drop_sat", a_drop, 8'd255);
    check("drop_sat_wr_ok", a_wr_ok, 1'b1);

    // reset during an active grant to client 1
    c_req = 3'b010;
    tick();
    check("mid_gnt", a_gnt, 3'b010);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_gnt", a_gnt, 3'b000);
    check("mid_rst_disp", a_disp, 2'd0);
    check("mid_rst_draw", a_draw, 2'd1);
    check("mid_rst_pend", a_pend, 1'b0);
    check("mid_rst_drop", a_drop, 8'd0);
    rst_n = 1'b1;
    c_req = 3'b100;
    tick();
    check("post_rst_gnt", a_gnt, 3'b100);
    c_rel = 3'b100;
    c_req = '0;
    tick();
    c_rel = '0;

    // double buffering on dut_b
    do_reset();
    rst_n = 1'b1;
    check("dbl_rst_wr_ok", b_wr_ok, 1'b1);
    check("dbl_rst_draw", b_draw, 2'd1);
    c_req = 3'b001;
    tick();
    check("dbl_wgnt", b_gnt, 3'b001);
    c_addr[0 +: CA_W] = CA_W'(0);
    c_addr[CA_W +: CA_W] = CA_W'(0);
    wr_data = 16'h1234;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("dbl_wr_ok_low", b_wr_ok, 1'b0);
    check("dbl_pend", b_pend, 1'b1);
    wr_data = 16'hDEAD;
    wr_en = 1'b1;
    frame_done = 1'b1;
    tick();
    wr_en = 1'b0;
    frame_done = 1'b0;
    check("dbl_done_ignored", b_draw, 2'd1);
    check("dbl_wr_ok_hold", b_wr_ok, 1'b0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("dbl_wr_ok_up", b_wr_ok, 1'b1);
    check("dbl_draw", b_draw, 2'd0);
    check("dbl_disp", b_disp, 2'd1);
    check("dbl_pend_clr", b_pend, 1'b0);
    c_rel = 3'b001;
    c_req = '0;
    tick();
    c_rel = '0;
    c_req = 3'b010;
    tick();
    check("dbl_rgnt", b_gnt, 3'b010);
    c_rd = 3'b010;
    tick();
    c_rd = '0;
    check("dbl_rd_data", b_rd_data, 16'h1234);
    check("dbl_rd_valid", b_rd_valid, 3'b010);
    c_rel = 3'b010;
    c_req = '0;
    tick();
    c_rel = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
